// File: rtl/flag_gen_pkg.sv
// Shared definitions for the multi-cycle compare/flag generator and the branch unit
// that decodes its {v, c, n, z} flag vector.
package flag_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int FLAG_V = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   // Counter width that stays legal when there is only one chunk
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/flag_gen_chunk_add.sv
// One CHUNK-bit slice of the serial subtractor: plain add with carry in/out,
// plus a zero detect on the slice sum for the running z accumulator.
module flag_gen_chunk_add #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             zero
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   assign zero        = (sum == '0);

endmodule

// File: rtl/flag_gen.sv
// Serial A-B flag generator: one CHUNK per cycle, LSB first, then holds {v,c,n,z}
// and the result until consumed. Define FLAG_GEN_FLUSH_EN to add the flush port.
module flag_gen
   import flag_gen_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
`ifdef FLAG_GEN_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       Flags,
   output logic [WIDTH-1:0] result
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = cnt_w(NCH);
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_CALC = CALC;
   localparam logic [1:0] ST_DONE = DONE;

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic             carry, zacc, kill;
   logic [WIDTH-1:0] a_q, b_q;
   logic [CHUNK-1:0] a_ch, b_ch, sum;
   logic             cout, ch_zero;

   // Subtraction as A + ~B + 1: the initial carry of 1 supplies the +1
   assign a_ch = a_q[count*CHUNK +: CHUNK];
   assign b_ch = ~b_q[count*CHUNK +: CHUNK];

   flag_gen_chunk_add #(.CHUNK(CHUNK)) u_add (
      .a    (a_ch),
      .b    (b_ch),
      .cin  (carry),
      .sum  (sum),
      .cout (cout),
      .zero (ch_zero)
   );

`ifdef FLAG_GEN_FLUSH_EN
   assign kill = flush & (state != ST_IDLE);
`else
   assign kill = 1'b0;
`endif

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         count  <= '0;
         carry  <= 1'b0;
         zacc   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         Flags  <= 4'b0000;
         result <= '0;
      end else if (kill) begin
         state  <= ST_IDLE;
         count  <= '0;
         Flags  <= 4'b0000;
         result <= '0;
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               a_q   <= A;
               b_q   <= B;
               count <= '0;
               carry <= 1'b1;
               zacc  <= 1'b1;
               state <= ST_CALC;
            end
            ST_CALC: begin
               result[count*CHUNK +: CHUNK] <= sum;
               carry <= cout;
               zacc  <= zacc & ch_zero;
               // Top chunk carries the sign, so the flags resolve on this edge
               if (count == LAST) begin
                  state         <= ST_DONE;
                  Flags[FLAG_C] <= cout;
                  Flags[FLAG_N] <= sum[CHUNK-1];
                  Flags[FLAG_Z] <= zacc & ch_zero;
                  Flags[FLAG_V] <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum[CHUNK-1] ^ a_q[WIDTH-1]);
               end else begin
                  count <= count + 1'b1;
               end
            end
            ST_DONE: if (out_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flag_gen.sv
// Bench for flag_gen: directed vectors with literal expectations plus an
// operation-level model checked every falling edge.
module tb_flag_gen;
   import flag_gen_pkg::*;

   localparam int W   = 32;
   localparam int NCH = W / 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] A = '0, B = '0;
   logic         in_ready, out_valid;
   logic [3:0]   Flags;
   logic [W-1:0] result;
`ifdef FLAG_GEN_FLUSH_EN
   logic         flush = 1'b0;
`endif

   int checks = 0;
   int errs   = 0;

   flag_gen #(.WIDTH(W), .CHUNK(8)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef FLAG_GEN_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Flags     (Flags),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Operation-level model: an accepted op becomes visible NCH edges later and
   // is retired by out_ready; expected values come straight from the flag rules.
   bit           busy = 1'b0;
   int           age  = 0;
   logic [W-1:0] m_res;
   logic [3:0]   m_flags;

   always @(negedge clk) begin
      if (reset) begin
         chk("m_rst_in_ready", in_ready, 1);
         chk("m_rst_out_valid", out_valid, 0);
         chk("m_rst_flags", Flags, 0);
         chk("m_rst_result", result, 0);
         busy = 1'b0;
      end else begin
         chk("m_in_ready", in_ready, !busy);
         chk("m_out_valid", out_valid, busy && age == NCH);
         if (busy && age == NCH) begin
            chk("m_result", result, m_res);
            chk("m_flags", Flags, m_flags);
         end
`ifdef FLAG_GEN_FLUSH_EN
         if (flush && busy) busy = 1'b0; else
`endif
         if (!busy) begin
            if (in_valid) begin
               busy  = 1'b1;
               age   = 0;
               m_res = A - B;
               m_flags[FLAG_C] = (A >= B);
               m_flags[FLAG_N] = m_res[W-1];
               m_flags[FLAG_Z] = (m_res == 0);
               m_flags[FLAG_V] = (A[W-1] != B[W-1]) && (m_res[W-1] != A[W-1]);
            end
         end else if (age < NCH) age++;
         else if (out_ready) busy = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ov(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] er, input logic [3:0] ef, input string nm);
      int n;
      A = a; B = b; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_ov(n);
      chk({nm, "_latency"}, n, NCH);
      chk({nm, "_result"}, result, er);
      chk({nm, "_flags"}, Flags, ef);
      if (out_ready) begin
         step();
         chk({nm, "_idle"}, in_ready, 1);
      end
   endtask

   initial begin
      int n;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_flags", Flags, 0);
      chk("rst_result", result, 0);
      step(); step();
      reset = 1'b0;

      op(32'd5, 32'd5, 32'h0, 4'b0101, "eq");
      op(32'd3, 32'd5, 32'hFFFFFFFE, 4'b0010, "lt");
      op(32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b1100, "ovf");
      op(32'd0, 32'd1, 32'hFFFFFFFF, 4'b0010, "zero_m1");
      op(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b1010, "ovf_neg");
      op(32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 4'b0110, "max");
      op(32'h100, 32'h1, 32'hFF, 4'b0100, "borrow");

      // Held output with stray in_valid during DONE
      out_ready = 1'b0;
      op(32'd7, 32'd2, 32'd5, 4'b0100, "hold");
      A = 32'd99; B = 32'd1; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_result", result, 5);
         chk("hold_flags", Flags, 4'b0100);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("hold_release_valid", out_valid, 0);
      chk("hold_release_ready", in_ready, 1);

      // Back-to-back spacing with in_valid and out_ready held high
      A = 32'd10; B = 32'd3; in_valid = 1'b1;
      wait_ov(n);
      n = 0;
      while (out_valid && n < 20) begin step(); n++; end
      while (!out_valid && n < 20) begin step(); n++; end
      chk("b2b_period", n, NCH + 2);
      in_valid = 1'b0;
      step(); step();

      // Reset in the middle of CALC with count=2
      A = 32'h12345678; B = 32'd1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      reset = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_flags", Flags, 0);
      chk("midrst_result", result, 0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("midrst_no_valid", out_valid, 0);
         step();
      end
      op(32'd1, 32'd1, 32'h0, 4'b0101, "after_rst");

`ifdef FLAG_GEN_FLUSH_EN
      out_ready = 1'b0;
      op(32'd9, 32'd4, 32'd5, 4'b0100, "pre_flush");
      flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", out_valid, 0);
      chk("flush_flags", Flags, 0);
      chk("flush_result", result, 0);
      chk("flush_ready", in_ready, 1);
      step();
      chk("flush_no_accept", in_ready, 1);
`endif

      step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/flag_gen.md
FLAG_GEN -- requirements
Module: flag_gen

Interface
- REQ-001: Parameter WIDTH, default 32, operand width in bits.
- REQ-002: Parameter CHUNK, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK.
- REQ-003: clk  input  1  sole clock, all state updates on rising edge.
- REQ-004: reset  input  1  asynchronous, active-high reset.
- REQ-005: in_valid  input  1  operands A/B present.
- REQ-006: in_ready  output  1  block can accept an operation.
- REQ-007: A  input  WIDTH  minuend (rs1).
- REQ-008: B  input  WIDTH  subtrahend (rs2).
- REQ-009: out_valid  output  1  Flags/result valid.
- REQ-010: out_ready  input  1  consumer (branch unit) accepts Flags.
- REQ-011: Flags  output  4  {v, c, n, z} of A-B, same bit order the branch unit decodes.
- REQ-012: result  output  WIDTH  A-B.

Function
- REQ-013: Computes A + ~B + 1 over WIDTH/CHUNK cycles, LSB chunk first, with a registered carry between chunks.
- REQ-014: FSM states IDLE, CALC, DONE; all outputs are registered or decoded from state only.
- REQ-015: IDLE: in_ready=1; on in_valid, latch A and B, set chunk count=0, carry=1, z accumulator=1, go to CALC.
- REQ-016: CALC: in_ready=0; per cycle, add chunk[count], write it into result, AND chunk-zero into z, update carry; after chunk WIDTH/CHUNK-1, go to DONE.
- REQ-017: Latency: out_valid rises exactly WIDTH/CHUNK rising edges after the accepting edge (4 with defaults).
- REQ-018: c = final carry out (1 when A >= B unsigned); n = result[WIDTH-1]; z = 1 when result == 0; v = (A[MSB] != B[MSB]) && (result[MSB] != A[MSB]).
- REQ-019: DONE: out_valid=1; Flags and result stay stable until out_ready=1; on out_valid&out_ready, go to IDLE.
- REQ-020: in_ready=0 in DONE; in_valid outside IDLE is ignored and no operands are latched.
- REQ-021: Back-to-back throughput is one operation per WIDTH/CHUNK+2 cycles when out_ready is held high.
- REQ-022: Chunk counter wraps to 0 only on the IDLE to CALC transition and never indexes past the last chunk.

Reset
- REQ-023: Reset asserted drives state=IDLE, in_ready=1, out_valid=0, Flags=4'b0000, result=0, count=0, carry=0, immediately and independently of clk.
- REQ-024: Reset mid-CALC or mid-DONE discards the operation; no out_valid pulse follows reset release.
- REQ-025: First in_valid is accepted on the first rising edge after reset deasserts.

Configuration
- REQ-026: Macro FLAG_GEN_FLUSH_EN, when defined, adds port flush (input, 1): flush=1 in CALC or DONE returns the FSM to IDLE on the next edge with out_valid=0 and Flags/result cleared; flush in IDLE has no effect; flush wins over a simultaneous out_ready or in_valid.
- REQ-027: Without FLAG_GEN_FLUSH_EN, the flush port does not exist and the behaviour is as in REQ-013..REQ-025.

Structure
- REQ-028: Shared package flag_gen_pkg holds the state enum (IDLE, CALC, DONE) and flag index constants FLAG_V=3, FLAG_C=2, FLAG_N=1, FLAG_Z=0, also used by the branch unit.
- REQ-029: One combinational sub-module flag_gen_chunk_add (CHUNK-bit add with carry in/out, chunk-zero output) is instantiated once.

Verification
- REQ-030: A=5, B=5 -> after 4 cycles out_valid=1, result=0, Flags=4'b0101.
- REQ-031: A=3, B=5 -> result=32'hFFFFFFFE, Flags=4'b0010 (blt and bltu both taken downstream).
- REQ-032: A=32'h80000000, B=1 -> result=32'h7FFFFFFF, Flags=4'b1100 (signed overflow).
- REQ-033: A=7, B=2 with out_ready held 0 for 6 cycles -> out_valid, result=5 and Flags=4'b0100 stay stable and in_ready=0 throughout; IDLE is entered one edge after out_ready=1.
- REQ-034: Reset pulsed at CALC count=2 -> all outputs zero and in_ready=1 immediately, no out_valid afterwards; the next op A=1, B=1 returns Flags=4'b0101.
- REQ-035: With FLAG_GEN_FLUSH_EN, flush=1 in DONE together with out_ready=1 -> IDLE next edge, out_valid=0, Flags=0.
